adc_pixel_sequencer: RTL and testbench

Scans the sensor pixel array row by row and drives the ADC controller's active-low startCapture/conversionComplete handshake once per pixel. Each returned sample is written to the frame buffer write port.
Sits directly upstream of the ADC controller, which it triggers, and consumes that controller's dataout word.
Firmware starts one full-frame scan per startFrame pulse.

---
 rtl/adc_pixel_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_adc_pixel_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_pixel_sequencer
// Description : Raster-scans a ROWS x COLS sensor array. For every pixel it
//               drives the row/column address, waits a settle period, then
//               runs the active-low startCapture / conversionComplete
//               handshake with the ADC controller. Each returned sample is
//               written to the frame buffer at the linear pixel index.
//               A capture or acknowledge phase that exceeds TIMEOUT_CYCLES
//               aborts the frame and raises a sticky error flag.
// Ports       : clk                 - system clock
//               reset               - asynchronous reset, active low
//               startFrame          - one-clock request to scan a frame
//               rowSel / colSel     - sensor row / column address
//               startCapture        - ADC trigger, active low
//               conversionComplete  - ADC done, active low
//               adcData             - ADC sample word
//               wrEn/wrAddr/wrData  - frame buffer write port
//               frameBusy           - frame in progress
//               frameDone           - one-clock pulse after last write
//               frameError          - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module adc_pixel_sequencer #(
    parameter int DATA_W         = 12,
    parameter int ROWS           = 112,
    parameter int COLS           = 112,
    parameter int ADDR_W         = 14,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       startFrame,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] rowSel,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] colSel,
    output logic                                       startCapture,
    input  logic                                       conversionComplete,
    input  logic [DATA_W-1:0]                          adcData,
    output logic                                       wrEn,
    output logic [ADDR_W-1:0]                          wrAddr,
    output logic [DATA_W-1:0]                          wrData,
    output logic                                       frameBusy,
    output logic                                       frameDone,
    output logic                                       frameError
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ROW_W-1:0] C_ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] C_COL_LAST    = COL_W'(COLS - 1);
    localparam logic [SET_W-1:0] C_SETTLE_INIT = SET_W'(SETTLE_CYCLES);
    // Abort fires on the TIMEOUT_CYCLES-th clock spent waiting.
    localparam logic [TMO_W-1:0] C_TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [ROW_W-1:0]   row_q,       row_d;
    logic [COL_W-1:0]   col_q,       col_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [DATA_W-1:0]  data_q,      data_d;
    logic               wr_en_q,     wr_en_d;
    logic               start_cap_q, start_cap_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               err_q,       err_d;
    logic [SET_W-1:0]   settle_q,    settle_d;
    logic [TMO_W-1:0]   tmo_q,       tmo_d;

    logic               last_pixel;
    logic               tmo_expired;

    assign last_pixel  = (row_q == C_ROW_LAST) && (col_q == C_COL_LAST);
    assign tmo_expired = (tmo_q == C_TMO_LAST);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_en_d     = 1'b0;
        start_cap_d = start_cap_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        settle_d    = settle_q;
        tmo_d       = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (startFrame) begin
                    row_d    = '0;
                    col_d    = '0;
                    addr_d   = '0;
                    settle_d = C_SETTLE_INIT;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    state_d  = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - 1'b1;
                end else begin
                    start_cap_d = 1'b0;
                    tmo_d       = '0;
                    state_d     = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (!conversionComplete) begin
                    data_d      = adcData;
                    wr_en_d     = 1'b1;
                    start_cap_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_ACK;
                end else if (tmo_expired) begin
                    start_cap_d = 1'b1;
                    err_d       = 1'b1;
                    busy_d      = 1'b0;
                    tmo_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_ACK: begin
                if (conversionComplete) begin
                    if (last_pixel) begin
                        // Addresses hold the final pixel after completion.
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        if (col_q == C_COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        addr_d   = addr_q + 1'b1;
                        settle_d = C_SETTLE_INIT;
                        state_d  = S_SETTLE;
                    end
                end else if (tmo_expired) begin
                    start_cap_d = 1'b1;
                    err_d       = 1'b1;
                    busy_d      = 1'b0;
                    tmo_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            start_cap_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            settle_q    <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            start_cap_q <= start_cap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            settle_q    <= settle_d;
            tmo_q       <= tmo_d;
        end
    end

    assign rowSel       = row_q;
    assign colSel       = col_q;
    assign startCapture = start_cap_q;
    assign wrEn         = wr_en_q;
    assign wrAddr       = addr_q;
    assign wrData       = data_q;
    assign frameBusy    = busy_q;
    assign frameDone    = done_q;
    assign frameError   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_pixel_sequencer
// Description : Self-checking bench for adc_pixel_sequencer. Two instances:
//               u_dut  (2x3, settle 2, timeout 20) with a programmable ADC
//               model, and u_dut0 (2x3, settle 0) with an immediate ADC.
//               Expected writes are queued when a sample is presented and
//               compared when the frame buffer write appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_pixel_sequencer;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int NPIX = ROWS * COLS;

    typedef struct packed {
        int addr;
        int data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_frame = 1'b0;
    logic [0:0]  row_sel;
    logic [1:0]  col_sel;
    logic        start_cap;
    logic        conv_cmp = 1'b1;
    logic [11:0] adc_data = '0;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy, done, err;

    logic        start_frame1 = 1'b0;
    logic [0:0]  row_sel1;
    logic [1:0]  col_sel1;
    logic        start_cap1;
    logic        conv_cmp1 = 1'b1;
    logic [11:0] adc_data1 = '0;
    logic        wr_en1;
    logic [13:0] wr_addr1;
    logic [11:0] wr_data1;
    logic        busy1, done1, err1;

    always #5 clk = ~clk;

    adc_pixel_sequencer #(
        .DATA_W(12), .ROWS(ROWS), .COLS(COLS), .ADDR_W(14),
        .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(20)
    ) u_dut (
        .clk(clk), .reset(reset), .startFrame(start_frame),
        .rowSel(row_sel), .colSel(col_sel), .startCapture(start_cap),
        .conversionComplete(conv_cmp), .adcData(adc_data),
        .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
        .frameBusy(busy), .frameDone(done), .frameError(err)
    );

    adc_pixel_sequencer #(
        .DATA_W(12), .ROWS(ROWS), .COLS(COLS), .ADDR_W(14),
        .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(20)
    ) u_dut0 (
        .clk(clk), .reset(reset), .startFrame(start_frame1),
        .rowSel(row_sel1), .colSel(col_sel1), .startCapture(start_cap1),
        .conversionComplete(conv_cmp1), .adcData(adc_data1),
        .wrEn(wr_en1), .wrAddr(wr_addr1), .wrData(wr_data1),
        .frameBusy(busy1), .frameDone(done1), .frameError(err1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // ADC model for u_dut: responds adc_delay negedges after startCapture
    // falls, or never when adc_hang is set. Sample = 0x100 + sensor index.
    // ------------------------------------------------------------------
    exp_t q0[$];
    int   adc_delay   = 2;
    bit   adc_hang    = 1'b0;
    int   m0          = 0;
    int   cnt0        = 0;
    int   pix_k       = 0;
    int   cc_fall_cyc = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0 == 2 && start_cap === 1'b1) begin
                conv_cmp = 1'b1;
                m0 = 0;
            end
            if (m0 == 0 && start_cap === 1'b0) begin
                m0 = 1;
                cnt0 = 0;
            end else if (m0 == 1 && start_cap === 1'b1) begin
                m0 = 0;
            end
            if (m0 == 1 && !adc_hang) begin
                if (cnt0 >= adc_delay) begin
                    adc_data    = 12'(32'h100 + int'(row_sel) * COLS + int'(col_sel));
                    conv_cmp    = 1'b0;
                    cc_fall_cyc = cyc;
                    e.addr = pix_k;
                    e.data = 32'h100 + pix_k;
                    q0.push_back(e);
                    pix_k++;
                    m0 = 2;
                end else begin
                    cnt0++;
                end
            end
        end
    end

    // Monitor for u_dut.
    int   wr_count    = 0;
    int   done_count  = 0;
    int   last_wr_cyc = 0;
    int   sc_fall_c   = 0;
    int   sc_rise_c   = 0;
    logic sc_prev     = 1'b1;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sc_prev && !start_cap) sc_fall_c = cyc;
            if (!sc_prev && start_cap) sc_rise_c = cyc;
            sc_prev = start_cap;
            if (wr_en) begin
                wr_count++;
                last_wr_cyc = cyc;
                if (q0.size() == 0) begin
                    chk_eq("sb_pending", q0.size(), 1);
                end else begin
                    e = q0.pop_front();
                    chk_eq("wr_addr", 32'(wr_addr), e.addr);
                    chk_eq("wr_data", 32'(wr_data), e.data);
                    chk_eq("row_sel", 32'(row_sel), e.addr / COLS);
                    chk_eq("col_sel", 32'(col_sel), e.addr % COLS);
                    chk_eq("sc_high_at_wr", 32'(start_cap), 1);
                    chk_eq("wr_latency", cyc, cc_fall_cyc + 1);
                end
            end
            if (done) begin
                done_count++;
                chk_eq("done_after_last_wr", cyc, last_wr_cyc + 1);
                chk_eq("busy_at_done", 32'(busy), 0);
                chk_eq("done_wr_count", wr_count, NPIX);
            end
        end
    end

    // ------------------------------------------------------------------
    // Immediate ADC model + monitor for u_dut0 (settle 0).
    // ------------------------------------------------------------------
    exp_t q1[$];
    int   k1 = 0;
    int   wr1 = 0;
    int   done1_count = 0;
    int   last_wr1 = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_en1) begin
                wr1++;
                if (q1.size() == 0) begin
                    chk_eq("s0_sb_pending", q1.size(), 1);
                end else begin
                    e = q1.pop_front();
                    chk_eq("s0_wr_addr", 32'(wr_addr1), e.addr);
                    chk_eq("s0_wr_data", 32'(wr_data1), e.data);
                end
                // ACK + one SETTLE clock + CAPTURE between writes.
                if (wr1 > 1) chk_eq("s0_spacing", cyc - last_wr1, 3);
                last_wr1 = cyc;
            end
            if (done1) done1_count++;
            if (start_cap1 === 1'b1) begin
                conv_cmp1 = 1'b1;
            end else if (conv_cmp1) begin
                adc_data1 = 12'(32'h200 + int'(row_sel1) * COLS + int'(col_sel1));
                conv_cmp1 = 1'b0;
                e.addr = k1;
                e.data = 32'h200 + k1;
                q1.push_back(e);
                k1++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing helpers
    // ------------------------------------------------------------------
    task automatic start_frame_pulse();
        q0.delete();
        pix_k = 0;
        wr_count = 0;
        done_count = 0;
        @(posedge clk); #1 start_frame = 1'b1;
        @(posedge clk); #1 start_frame = 1'b0;
        chk_eq("busy_after_start", 32'(busy), 1);
        chk_eq("err_after_start", 32'(err), 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_count == 0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk_eq({tag, "_done_seen"}, 32'(done_count > 0), 1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_count < target && n < 3000) begin
            @(negedge clk); #2;
            n++;
        end
        chk_eq("writes_reached", 32'(wr_count >= target), 1);
    endtask

    task automatic post_frame(input string tag);
        chk_eq({tag, "_wr_count"}, wr_count, NPIX);
        chk_eq({tag, "_done_count"}, done_count, 1);
        chk_eq({tag, "_busy"}, 32'(busy), 0);
        chk_eq({tag, "_err"}, 32'(err), 0);
        chk_eq({tag, "_row_hold"}, 32'(row_sel), ROWS - 1);
        chk_eq({tag, "_col_hold"}, 32'(col_sel), COLS - 1);
        chk_eq({tag, "_addr_hold"}, 32'(wr_addr), NPIX - 1);
        chk_eq({tag, "_sb_empty"}, q0.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_sc"}, 32'(start_cap), 1);
        chk_eq({tag, "_wr_en"}, 32'(wr_en), 0);
        chk_eq({tag, "_busy"}, 32'(busy), 0);
        chk_eq({tag, "_done"}, 32'(done), 0);
        chk_eq({tag, "_err"}, 32'(err), 0);
        chk_eq({tag, "_row"}, 32'(row_sel), 0);
        chk_eq({tag, "_col"}, 32'(col_sel), 0);
        chk_eq({tag, "_addr"}, 32'(wr_addr), 0);
        chk_eq({tag, "_data"}, 32'(wr_data), 0);
    endtask

    initial begin
        int n;
        int wr_before;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk) reset = 1'b1;

        // Normal frame, short ADC latency.
        adc_delay = 2;
        start_frame_pulse();
        wait_done("t1");
        post_frame("t1");

        // Slow ADC (7 clocks) with a stray startFrame mid-frame.
        adc_delay = 7;
        start_frame_pulse();
        wait_writes(2);
        @(posedge clk); #1 start_frame = 1'b1;
        @(posedge clk); #1 start_frame = 1'b0;
        chk_eq("t4_busy_after_stray", 32'(busy), 1);
        wait_done("t2");
        post_frame("t2");

        // ADC never answers: timeout abort, then a clean recovery frame.
        adc_hang = 1'b1;
        start_frame_pulse();
        n = 0;
        while (err !== 1'b1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk_eq("t3_err_set", 32'(err), 1);
        chk_eq("t3_timeout_len", sc_rise_c - sc_fall_c, 20);
        chk_eq("t3_sc", 32'(start_cap), 1);
        chk_eq("t3_busy", 32'(busy), 0);
        chk_eq("t3_no_wr", wr_count, 0);
        chk_eq("t3_no_done", done_count, 0);
        repeat (5) @(negedge clk);
        #1;
        chk_eq("t3_err_sticky", 32'(err), 1);
        adc_hang = 1'b0;
        adc_delay = 1;
        start_frame_pulse();
        wait_done("t3b");
        post_frame("t3b");

        // Asynchronous reset during ACK of pixel 3.
        adc_delay = 3;
        start_frame_pulse();
        wait_writes(4);
        reset = 1'b0;
        #1;
        chk_reset_outputs("t5_async");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wr_before = wr_count;
        repeat (30) @(negedge clk);
        #1;
        chk_eq("t5_no_new_wr", wr_count, wr_before);
        chk_eq("t5_idle_busy", 32'(busy), 0);
        chk_eq("t5_idle_sc", 32'(start_cap), 1);
        chk_eq("t5_no_done", done_count, 0);

        // Settle 0 instance with immediate ADC.
        @(posedge clk); #1 start_frame1 = 1'b1;
        @(posedge clk); #1 start_frame1 = 1'b0;
        n = 0;
        while (done1_count == 0 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (4) @(negedge clk);
        #1;
        chk_eq("t6_done_count", done1_count, 1);
        chk_eq("t6_wr_count", wr1, NPIX);
        chk_eq("t6_busy", 32'(busy1), 0);
        chk_eq("t6_err", 32'(err1), 0);
        chk_eq("t6_addr_hold", 32'(wr_addr1), NPIX - 1);
        chk_eq("t6_sb_empty", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
